// File: rtl/morse_symbol_sequencer.sv
// Morse keying engine: one letter per valid/ready handshake; optional inter-letter gap via MORSE_SEQ_LETTER_GAP_EN.
// Latency: led/busy 1 cycle after accept. Backpressure: in_ready low while a letter is in flight or abort is high.
module morse_symbol_sequencer #(
    parameter int MAX_LEN     = 8,
    parameter int LEN_W       = $clog2(MAX_LEN + 1),
    parameter int UNIT_CYCLES = 25_000_000,
    parameter int DASH_UNITS  = 3,
    parameter int GAP_UNITS   = 3
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [MAX_LEN-1:0] in_pattern,
    input  logic [LEN_W-1:0]   in_length,
    input  logic               abort,
    output logic               led,
    output logic               busy,
    output logic               done
);

    localparam int CW   = (UNIT_CYCLES > 1) ? $clog2(UNIT_CYCLES) : 1;
    localparam int UMAX = (DASH_UNITS > GAP_UNITS) ? DASH_UNITS : GAP_UNITS;
    localparam int UW   = $clog2(UMAX);

    typedef enum logic [1:0] {
        S_IDLE,
        S_MARK,
`ifdef MORSE_SEQ_LETTER_GAP_EN
        S_GAP,
`endif
        S_SPACE
    } state_t;

    state_t             state_q, state_d;
    logic [MAX_LEN-1:0] pat_q, pat_d;
    logic [LEN_W-1:0]   rem_q, rem_d;
    logic [CW-1:0]      cyc_q, cyc_d;
    logic [UW-1:0]      unit_q, unit_d;
    logic               led_q, led_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    logic [LEN_W-1:0]   len_clamped;
    logic               unit_end;
    logic [CW-1:0]      cyc_next;
    logic [UW-1:0]      mark_last;

    assign in_ready = (state_q == S_IDLE) && !abort;
    assign led      = led_q;
    assign busy     = busy_q;
    assign done     = done_q;

    always_comb begin
        len_clamped = (in_length > LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : in_length;
        unit_end    = (cyc_q == CW'(UNIT_CYCLES - 1));
        cyc_next    = unit_end ? '0 : cyc_q + CW'(1);
        mark_last   = pat_q[MAX_LEN-1] ? UW'(DASH_UNITS - 1) : '0;
    end

    always_comb begin
        state_d = state_q;
        pat_d   = pat_q;
        rem_d   = rem_q;
        cyc_d   = cyc_q;
        unit_d  = unit_q;
        done_d  = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (in_valid && in_ready) begin
                    pat_d  = in_pattern;
                    rem_d  = len_clamped;
                    cyc_d  = '0;
                    unit_d = '0;
                    if (len_clamped == '0) begin
                        done_d = 1'b1;
                    end else begin
                        state_d = S_MARK;
                    end
                end
            end
            S_MARK: begin
                cyc_d = cyc_next;
                if (unit_end) begin
                    if (unit_q == mark_last) begin
                        unit_d  = '0;
                        state_d = S_SPACE;
                    end else begin
                        unit_d = unit_q + UW'(1);
                    end
                end
            end
            S_SPACE: begin
                cyc_d = cyc_next;
                if (unit_end) begin
                    pat_d = pat_q << 1;
                    rem_d = rem_q - LEN_W'(1);
                    if (rem_q == LEN_W'(1)) begin
`ifdef MORSE_SEQ_LETTER_GAP_EN
                        if (GAP_UNITS > 1) begin
                            state_d = S_GAP;
                        end else begin
                            state_d = S_IDLE;
                            done_d  = 1'b1;
                        end
`else
                        state_d = S_IDLE;
                        done_d  = 1'b1;
`endif
                    end else begin
                        state_d = S_MARK;
                    end
                end
            end
`ifdef MORSE_SEQ_LETTER_GAP_EN
            // Trailing symbol space already provided one unit of the gap.
            S_GAP: begin
                cyc_d = cyc_next;
                if (unit_end) begin
                    if (unit_q == UW'(GAP_UNITS - 2)) begin
                        unit_d  = '0;
                        state_d = S_IDLE;
                        done_d  = 1'b1;
                    end else begin
                        unit_d = unit_q + UW'(1);
                    end
                end
            end
`endif
            default: state_d = S_IDLE;
        endcase

        if (abort && (state_q != S_IDLE)) begin
            state_d = S_IDLE;
            pat_d   = '0;
            rem_d   = '0;
            cyc_d   = '0;
            unit_d  = '0;
            done_d  = 1'b0;
        end

        led_d  = (state_d == S_MARK);
        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            pat_q   <= '0;
            rem_q   <= '0;
            cyc_q   <= '0;
            unit_q  <= '0;
            led_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pat_q   <= pat_d;
            rem_q   <= rem_d;
            cyc_q   <= cyc_d;
            unit_q  <= unit_d;
            led_q   <= led_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

endmodule

// File: tb/tb_morse_symbol_sequencer.sv
// Directed bench for morse_symbol_sequencer with a small unit period; expected led traces are built from the letter pattern.
module tb_morse_symbol_sequencer;

    localparam int UC = 2;
    localparam int DU = 3;
    localparam int GU = 3;
    localparam int ML = 8;
    localparam int LW = 4;
`ifdef MORSE_SEQ_LETTER_GAP_EN
    localparam int GE = (GU - 1) * UC;
`else
    localparam int GE = 0;
`endif

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          in_valid = 1'b0;
    logic          abort = 1'b0;
    logic [ML-1:0] in_pattern = '0;
    logic [LW-1:0] in_length = '0;
    logic          in_ready;
    logic          led;
    logic          busy;
    logic          done;

    int errors = 0;
    int checks = 0;

    morse_symbol_sequencer #(
        .MAX_LEN    (ML),
        .LEN_W      (LW),
        .UNIT_CYCLES(UC),
        .DASH_UNITS (DU),
        .GAP_UNITS  (GU)
    ) u_dut (
        .clock     (clock),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_pattern(in_pattern),
        .in_length (in_length),
        .abort     (abort),
        .led       (led),
        .busy      (busy),
        .done      (done)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        if (obs != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Offers one letter, then samples each cycle until busy drops; the last sample is the done cycle.
    task automatic run_letter(input string tag, input logic [ML-1:0] pat, input logic [LW-1:0] len);
        int  n;
        int  exp_q[$];
        int  obs_q[$];
        int  busy_cnt;
        int  done_cnt;
        int  mism;
        int  last_done;
        bit  ended;
        n = (len > ML) ? ML : int'(len);
        for (int s = 0; s < n; s++) begin
            int u;
            u = pat[ML-1-s] ? DU : 1;
            repeat (u * UC) exp_q.push_back(1);
            repeat (UC) exp_q.push_back(0);
        end
        repeat (GE) exp_q.push_back(0);

        @(negedge clock);
        check({tag, "_rdy"}, int'(in_ready), 1);
        in_valid   = 1'b1;
        in_pattern = pat;
        in_length  = len;
        @(posedge clock);
        #1;
        in_valid   = 1'b0;
        in_pattern = ~pat;
        in_length  = 4'd3;

        busy_cnt  = 0;
        done_cnt  = 0;
        last_done = 0;
        ended     = 1'b0;
        for (int i = 0; i < 400 && !ended; i++) begin
            @(negedge clock);
            if (done) done_cnt++;
            if (busy) begin
                obs_q.push_back(int'(led));
                busy_cnt++;
            end else begin
                ended     = 1'b1;
                last_done = int'(done);
                check({tag, "_led_idle"}, int'(led), 0);
            end
        end
        check({tag, "_ended"}, int'(ended), 1);
        check({tag, "_busy_cycles"}, busy_cnt, exp_q.size());
        mism = 0;
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++)
            if (obs_q[i] != exp_q[i]) mism++;
        check({tag, "_trace_mism"}, mism, 0);
        check({tag, "_done_cnt"}, done_cnt, 1);
        check({tag, "_done_last"}, last_done, 1);
        @(negedge clock);
        check({tag, "_done_pulse"}, int'(done), 0);
    endtask

    initial begin : main
        int obs_q[$];
        int exp_q[$];
        int donec;
        int mism;
        int gap;
        int idx;

        #12;
        check("rst_led", int'(led), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_rdy", int'(in_ready), 1);
        @(negedge clock);
        reset = 1'b0;

        run_letter("E", 8'h00, 4'd1);
        run_letter("A", 8'h40, 4'd2);
        run_letter("LEN0", 8'hFF, 4'd0);
        run_letter("LEN15", 8'hA5, 4'd15);
        run_letter("LEN8", 8'h3C, 4'd8);

        // Two E letters with in_valid held: second accepted on the done cycle.
        @(negedge clock);
        in_valid   = 1'b1;
        in_pattern = 8'h00;
        in_length  = 4'd1;
        @(posedge clock);
        #1;
        repeat (2) begin
            repeat (UC) exp_q.push_back(1);
            repeat (UC + GE) exp_q.push_back(0);
        end
        exp_q.insert(2 * UC + GE, 0);
        exp_q.push_back(0);
        donec = 0;
        for (int i = 0; i < exp_q.size(); i++) begin
            @(negedge clock);
            obs_q.push_back(int'(led));
            if (done) donec++;
            if (donec == 1 && busy && in_valid) in_valid = 1'b0;
        end
        in_valid = 1'b0;
        mism = 0;
        for (int i = 0; i < exp_q.size(); i++)
            if (obs_q[i] != exp_q[i]) mism++;
        check("b2b_trace_mism", mism, 0);
        check("b2b_done_cnt", donec, 2);
        gap = 0;
        idx = UC;
        while (idx < obs_q.size() && obs_q[idx] == 0) begin
            gap++;
            idx++;
        end
        // Low run = symbol space + gap extension + the single IDLE/done handshake cycle.
        check("b2b_low_run", gap, UC + GE + 1);

        // Abort in the middle of B's leading dash.
        @(negedge clock);
        in_valid   = 1'b1;
        in_pattern = 8'h80;
        in_length  = 4'd4;
        @(posedge clock);
        #1;
        in_valid = 1'b0;
        repeat (2) @(negedge clock);
        check("abort_pre_led", int'(led), 1);
        abort = 1'b1;
        @(posedge clock);
        #1;
        check("abort_led", int'(led), 0);
        check("abort_busy", int'(busy), 0);
        check("abort_done", int'(done), 0);
        abort = 1'b0;
        donec = 0;
        repeat (3) begin
            @(negedge clock);
            if (done || busy) donec++;
        end
        check("abort_quiet", donec, 0);

        // Abort in IDLE blocks a simultaneous offer.
        @(negedge clock);
        abort      = 1'b1;
        in_valid   = 1'b1;
        in_pattern = 8'h00;
        in_length  = 4'd1;
        #1;
        check("idle_abort_rdy", int'(in_ready), 0);
        @(posedge clock);
        #1;
        check("idle_abort_busy", int'(busy), 0);
        @(negedge clock);
        check("idle_abort_busy2", int'(busy), 0);
        check("idle_abort_done", int'(done), 0);
        abort    = 1'b0;
        in_valid = 1'b0;

        // Reset between edges while marking.
        @(negedge clock);
        in_valid   = 1'b1;
        in_pattern = 8'h40;
        in_length  = 4'd2;
        @(posedge clock);
        #1;
        in_valid = 1'b0;
        @(negedge clock);
        check("rst_mid_pre_led", int'(led), 1);
        #2;
        reset = 1'b1;
        #1;
        check("rst_mid_led", int'(led), 0);
        check("rst_mid_busy", int'(busy), 0);
        check("rst_mid_done", int'(done), 0);
        @(negedge clock);
        reset = 1'b0;
        #1;
        check("rst_rel_rdy", int'(in_ready), 1);
        run_letter("E_after_rst", 8'h00, 4'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached, errors=%0d checks=%0d", errors, checks);
        $fatal(1);
    end

endmodule
